if_id_stage: RTL
================

# if_id_stage

Fetch-side front end of the five-stage MIPS pipeline: the program counter register, PC+4 / branch-redirect selection, and the IF/ID pipeline register. It sits directly upstream of the load-use hazard detection unit. It consumes that unit's PC-write, IF/ID-hold and flush controls, and feeds it the rs/rt fields of the instruction held in IF/ID. Optional saturating counters record stall and flush cycles for performance analysis.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of the optional stall/flush counters
- clk_i  in  1  pipeline clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- pc_write_i  in  1  1 = PC may advance; 0 = PC holds (load-use stall)
- ifid_hold_i  in  1  1 = IF/ID register holds its contents
- if_flush_i  in  1  hazard-unit flush request for IF/ID
- branch_taken_i  in  1  branch/jump resolved taken in ID this cycle
- branch_target_i  in  32  redirect address, valid when branch_taken_i=1
- instr_i  in  32  instruction memory read data for address pc_o (combinational IM)
- pc_o  out  32  current fetch address to instruction memory
- ifid_pc4_o  out  32  PC+4 of the instruction in IF/ID
- ifid_instr_o  out  32  instruction in IF/ID
- ifid_valid_o  out  1  IF/ID holds a real (non-bubble) instruction
- rs_addr_o  out  5  ifid_instr_o[25:21], to hazard unit
- rt_addr_o  out  5  ifid_instr_o[20:16], to hazard unit
- stall_cnt_o  out  CNT_W  stall cycles (STALL_CNT_EN only)
- flush_cnt_o  out  CNT_W  flush cycles (STALL_CNT_EN only)

## Operation
- Next PC: branch_taken_i ? branch_target_i : pc_o + 4. Addition modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of branch_target_i are forced to 0.
- PC update priority per cycle: rst_i > branch_taken_i > !pc_write_i (hold) > advance.
- IF/ID update priority per cycle:
  - rst_i: load bubble.
  - branch_taken_i: load bubble; kills the wrong-path fetch.
  - ifid_hold_i: hold.
  - if_flush_i: load bubble.
  - otherwise: load {pc_o+4, instr_i, valid=1}.
- Bubble: ifid_instr_o=32'h0000_0000 (sll $0,$0,0 NOP), ifid_pc4_o=0, ifid_valid_o=0.
- Hold outranks if_flush_i. The hazard unit asserts both together on a load-use stall, and the stalled instruction must survive.
- branch_taken_i together with ifid_hold_i is illegal; ID gates branches during stalls. If it occurs, the branch wins as stated above.
- rs_addr_o/rt_addr_o are combinational slices of the registered instruction. A bubble yields 0/0, and register $0 never causes a false stall downstream.

## Timing
- Reset values: pc_o=RESET_PC; ifid_pc4_o=0; ifid_instr_o=0; ifid_valid_o=0; counters 0.
- Fetch latency: the instruction at pc_o in cycle N appears on ifid_instr_o in cycle N+1.
- Stall: with pc_write_i=0 and ifid_hold_i=1 for k cycles, pc_o and all IF/ID outputs are frozen for exactly k cycles. Progress resumes the cycle after release.
- Redirect: branch_taken_i in cycle N gives pc_o=target and an IF/ID bubble in N+1. The target instruction is in IF/ID in N+2, a one-cycle penalty.
- Reset asserted mid-stall or mid-redirect overrides everything in that cycle.

## Configuration
- STALL_CNT_EN defined:
  - stall_cnt_o increments each cycle with ifid_hold_i=1 and rst_i=0.
  - flush_cnt_o increments each cycle that IF/ID loads a bubble due to branch_taken_i or an honoured if_flush_i.
  - Both saturate at 2^CNT_W-1 and clear only on rst_i.
- STALL_CNT_EN undefined: counter logic is absent and both outputs are tied to 0.

## Structure
- Shared pipeline package holds: the NOP encoding 32'h0000_0000, PC_STEP=4, the rs/rt field positions, and the reset-PC default.
- One sub-module, sat_counter (parameter W; inputs clk_i, rst_i, inc_i; output cnt_o). It is instantiated twice under STALL_CNT_EN.

## Test plan
- Reset then 4 free-running cycles, IM returning 32'h2001_0005 at address 0 -> pc_o 0,4,8,12. In cycle 1: ifid_instr_o=32'h2001_0005, ifid_pc4_o=4, valid=1.
- pc_write_i=0, ifid_hold_i=1, if_flush_i=1 for 2 cycles with pc_o=8 -> pc_o stays 8 and IF/ID unchanged. If STALL_CNT_EN: stall_cnt_o=2 and flush_cnt_o=0.
- branch_taken_i=1, target 32'h0000_0043 at pc_o=12 -> next cycle pc_o=32'h40, ifid_valid_o=0, ifid_instr_o=0. The cycle after holds the target instruction.
- PC at 32'hFFFF_FFFC, free run -> pc_o wraps to 0 and ifid_pc4_o=0 for the fetched instruction.
- rst_i asserted during an active stall with pc_o=32'h20 -> next cycle pc_o=RESET_PC, bubble in IF/ID, counters 0.
- STALL_CNT_EN with CNT_W=2 and 5 hold cycles -> stall_cnt_o saturates at 3.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch front end: NOP encoding, PC step,
// register-field positions and the IF/ID register layout.
package if_id_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/if_id_stage_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_d, cnt_q;

    // Next count: step by one unless already pinned at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end: PC register, PC+4 / redirect select and IF/ID register.
// Optional stall/flush performance counters are built when STALL_CNT_EN
// is defined; otherwise their outputs are tied to zero.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pc_write_i,
    input  logic             ifid_hold_i,
    input  logic             if_flush_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic [31:0]      instr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_pc4_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [4:0]       rs_addr_o,
    output logic [4:0]       rt_addr_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [31:0] pc_d, pc_q;
    logic [31:0] pc4;
    ifid_t       ifid_d, ifid_q;

    assign pc4 = pc_q + PC_STEP;

    // Next PC: redirect beats stall-hold beats sequential advance.
    always_comb begin
        // NOTE: default assignment first so every path drives pc_d; no latch.
        pc_d = pc4;
        if (branch_taken_i)   pc_d = branch_target_i & PC_ALIGN_MASK;
        else if (!pc_write_i) pc_d = pc_q;
    end

    // Next IF/ID: a redirect kills the wrong-path fetch; hold outranks flush
    // so a load-use stalled instruction survives.
    always_comb begin
        ifid_d = ifid_q;
        if (branch_taken_i)   ifid_d = IFID_BUBBLE;
        else if (ifid_hold_i) ifid_d = ifid_q;
        else if (if_flush_i)  ifid_d = IFID_BUBBLE;
        else                  ifid_d = '{pc4: pc4, instr: instr_i, valid: 1'b1};
    end

    // PC and IF/ID registers with synchronous reset to a bubble.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so all flops sample pre-edge values.
        if (rst_i) begin
            pc_q   <= RESET_PC;
            ifid_q <= IFID_BUBBLE;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign pc_o         = pc_q;
    assign ifid_pc4_o   = ifid_q.pc4;
    assign ifid_instr_o = ifid_q.instr;
    assign ifid_valid_o = ifid_q.valid;
    assign rs_addr_o    = ifid_q.instr[RS_MSB:RS_LSB];
    assign rt_addr_o    = ifid_q.instr[RT_MSB:RT_LSB];

`ifdef STALL_CNT_EN
    logic flush_inc;

    assign flush_inc = branch_taken_i | (if_flush_i & ~ifid_hold_i);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ifid_hold_i),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
